// File: rtl/cv32e40p_x_result_queue.sv
// Sits between the core X-interface and a coprocessor. Requests pass through under an
// outstanding-offload limit, and results are buffered and returned to the core in order.
module cv32e40p_x_result_queue #(
  parameter int RESULT_DEPTH    = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             x_valid_i,
  output logic             x_ready_o,
  input  logic [31:0]      x_instr_data_i,
  input  logic [95:0]      x_rs_i,
  input  logic [2:0]       x_rs_valid_i,
  output logic             x_accept_o,
  output logic             x_is_mem_op_o,
  output logic             x_writeback_o,
  output logic             x_rvalid_o,
  input  logic             x_rready_i,
  output logic [4:0]       x_rd_o,
  output logic [31:0]      x_data_o,
  output logic             x_dualwb_o,
  output logic             x_type_o,
  output logic             x_error_o,
  output logic             c_valid_o,
  input  logic             c_ready_i,
  output logic [31:0]      c_instr_data_o,
  output logic [95:0]      c_rs_o,
  output logic [2:0]       c_rs_valid_o,
  input  logic             c_accept_i,
  input  logic             c_is_mem_op_i,
  input  logic             c_writeback_i,
  input  logic             c_rvalid_i,
  output logic             c_rready_o,
  input  logic [4:0]       c_rd_i,
  input  logic [31:0]      c_data_i,
  input  logic             c_dualwb_i,
  input  logic             c_type_i,
  input  logic             c_error_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_unexpected_o,
  output logic             err_rd_mismatch_o
);

  localparam int TAG_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int RES_AW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int RCNT_W = $clog2(RESULT_DEPTH + 1);
  localparam int ENT_W  = 40;

  logic [4:0]        tag_mem [MAX_OUTSTANDING];
  logic [ENT_W-1:0]  res_mem [RESULT_DEPTH];

  logic [TAG_AW-1:0] tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
  logic [CNT_W-1:0]  tag_cnt_q, tag_cnt_d;
  logic [RES_AW-1:0] res_wptr_q, res_wptr_d, res_rptr_q, res_rptr_d;
  logic [RCNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              err_unexp_q, err_unexp_d, err_mism_q, err_mism_d;

  logic stall, tag_full, tag_empty, res_full, res_empty;
  logic tag_push, tag_pop, res_push, res_pop, res_hs, rd_mismatch;
  logic [4:0]       tag_head;
  logic [ENT_W-1:0] res_head, res_entry;

  assign tag_full  = (tag_cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign tag_empty = (tag_cnt_q == '0);
  assign res_full  = (res_cnt_q == RCNT_W'(RESULT_DEPTH));
  assign res_empty = (res_cnt_q == '0);
  assign stall     = (outst_q == CNT_W'(MAX_OUTSTANDING)) | tag_full;

  assign c_valid_o      = x_valid_i & ~stall;
  assign x_ready_o      = c_ready_i & ~stall;
  assign c_instr_data_o = x_instr_data_i;
  assign c_rs_o         = x_rs_i;
  assign c_rs_valid_o   = x_rs_valid_i;
  assign x_accept_o     = c_accept_i;
  assign x_is_mem_op_o  = c_is_mem_op_i;
  assign x_writeback_o  = c_writeback_i;

  assign tag_push = x_valid_i & x_ready_o & c_accept_i & c_writeback_i;
  assign tag_head = tag_mem[tag_rptr_q];

  assign c_rready_o  = ~res_full;
  assign res_hs      = c_rvalid_i & c_rready_o;
  assign res_push    = res_hs & ~tag_empty;
  assign tag_pop     = res_push;
  assign rd_mismatch = res_push & (c_rd_i != tag_head);
  // A mismatched rd is still delivered, but marked as an error so the core can trap on it.
  assign res_entry   = {c_rd_i, c_data_i, c_dualwb_i, c_type_i, c_error_i | rd_mismatch};

  assign res_head   = res_mem[res_rptr_q];
  assign x_rvalid_o = ~res_empty;
  assign res_pop    = x_rvalid_o & x_rready_i;
  assign x_rd_o     = res_head[39:35];
  assign x_data_o   = res_head[34:3];
  assign x_dualwb_o = res_head[2];
  assign x_type_o   = res_head[1];
  assign x_error_o  = res_head[0];

  assign outstanding_o     = outst_q;
  assign err_unexpected_o  = err_unexp_q;
  assign err_rd_mismatch_o = err_mism_q;

  always_comb begin
    tag_wptr_d = tag_wptr_q;
    tag_rptr_d = tag_rptr_q;
    tag_cnt_d  = tag_cnt_q;
    res_wptr_d = res_wptr_q;
    res_rptr_d = res_rptr_q;
    res_cnt_d  = res_cnt_q;
    outst_d    = outst_q;
    err_unexp_d = err_unexp_q | (res_hs & tag_empty);
    err_mism_d  = err_mism_q | rd_mismatch;

    if (tag_push)
      tag_wptr_d = (tag_wptr_q == TAG_AW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wptr_q + 1'b1;
    if (tag_pop)
      tag_rptr_d = (tag_rptr_q == TAG_AW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rptr_q + 1'b1;
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase

    if (res_push)
      res_wptr_d = (res_wptr_q == RES_AW'(RESULT_DEPTH - 1)) ? '0 : res_wptr_q + 1'b1;
    if (res_pop)
      res_rptr_d = (res_rptr_q == RES_AW'(RESULT_DEPTH - 1)) ? '0 : res_rptr_q + 1'b1;
    case ({res_push, res_pop})
      2'b10:   res_cnt_d = res_cnt_q + 1'b1;
      2'b01:   res_cnt_d = res_cnt_q - 1'b1;
      default: res_cnt_d = res_cnt_q;
    endcase

    // Outstanding spans issue to delivery, so it counts queued tags plus buffered results.
    case ({tag_push, res_pop})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_wptr_q  <= '0;
      tag_rptr_q  <= '0;
      tag_cnt_q   <= '0;
      res_wptr_q  <= '0;
      res_rptr_q  <= '0;
      res_cnt_q   <= '0;
      outst_q     <= '0;
      err_unexp_q <= 1'b0;
      err_mism_q  <= 1'b0;
    end else begin
      tag_wptr_q  <= tag_wptr_d;
      tag_rptr_q  <= tag_rptr_d;
      tag_cnt_q   <= tag_cnt_d;
      res_wptr_q  <= res_wptr_d;
      res_rptr_q  <= res_rptr_d;
      res_cnt_q   <= res_cnt_d;
      outst_q     <= outst_d;
      err_unexp_q <= err_unexp_d;
      err_mism_q  <= err_mism_d;
    end
  end

  // Storage carries no reset; occupancy is governed entirely by the pointers and counts.
  always_ff @(posedge clk_i) begin
    if (tag_push) tag_mem[tag_wptr_q] <= x_instr_data_i[11:7];
    if (res_push) res_mem[res_wptr_q] <= res_entry;
  end

endmodule

// File: tb/tb_cv32e40p_x_result_queue.sv
// Directed bench for cv32e40p_x_result_queue: request gating, result ordering,
// backpressure, protocol-error flags and asynchronous reset.
module tb_cv32e40p_x_result_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_valid, x_ready, x_accept, x_is_mem_op, x_writeback;
  logic [31:0] x_instr;
  logic [95:0] x_rs;
  logic [2:0]  x_rs_valid;
  logic        x_rvalid, x_rready;
  logic [4:0]  x_rd;
  logic [31:0] x_data;
  logic        x_dualwb, x_type, x_error;
  logic        c_valid, c_ready;
  logic [31:0] c_instr;
  logic [95:0] c_rs;
  logic [2:0]  c_rs_valid;
  logic        c_accept, c_is_mem_op, c_writeback;
  logic        c_rvalid, c_rready;
  logic [4:0]  c_rd;
  logic [31:0] c_data;
  logic        c_dualwb, c_type, c_error;
  logic [2:0]  outstanding;
  logic        err_unexp, err_mism;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cv32e40p_x_result_queue dut (
    .clk_i(clk), .rst_ni(rst_n),
    .x_valid_i(x_valid), .x_ready_o(x_ready), .x_instr_data_i(x_instr),
    .x_rs_i(x_rs), .x_rs_valid_i(x_rs_valid),
    .x_accept_o(x_accept), .x_is_mem_op_o(x_is_mem_op), .x_writeback_o(x_writeback),
    .x_rvalid_o(x_rvalid), .x_rready_i(x_rready), .x_rd_o(x_rd), .x_data_o(x_data),
    .x_dualwb_o(x_dualwb), .x_type_o(x_type), .x_error_o(x_error),
    .c_valid_o(c_valid), .c_ready_i(c_ready), .c_instr_data_o(c_instr),
    .c_rs_o(c_rs), .c_rs_valid_o(c_rs_valid),
    .c_accept_i(c_accept), .c_is_mem_op_i(c_is_mem_op), .c_writeback_i(c_writeback),
    .c_rvalid_i(c_rvalid), .c_rready_o(c_rready), .c_rd_i(c_rd), .c_data_i(c_data),
    .c_dualwb_i(c_dualwb), .c_type_i(c_type), .c_error_i(c_error),
    .outstanding_o(outstanding), .err_unexpected_o(err_unexp), .err_rd_mismatch_o(err_mism)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; x_valid = 0; x_instr = 0; x_rs = 0; x_rs_valid = 0; x_rready = 1;
    c_ready = 1; c_accept = 1; c_is_mem_op = 0; c_writeback = 1; c_rvalid = 0;
    c_rd = 0; c_data = 0; c_dualwb = 0; c_type = 0; c_error = 0;
    #1;
    chk("rst_rvalid", x_rvalid, 0);
    chk("rst_outst", outstanding, 0);
    chk("rst_err_unexp", err_unexp, 0);
    chk("rst_err_mism", err_mism, 0);
    chk("rst_c_rready", c_rready, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single offload round trip
    @(negedge clk);
    x_valid = 1; x_instr = 32'h0000_0A8B; x_rs = {32'h3, 32'h2, 32'h1}; x_rs_valid = 3'b101;
    c_is_mem_op = 1;
    #1;
    chk("t1_c_valid", c_valid, 1);
    chk("t1_x_ready", x_ready, 1);
    chk("t1_c_instr", c_instr, 32'h0000_0A8B);
    chk("t1_c_rs", c_rs, {32'h3, 32'h2, 32'h1});
    chk("t1_c_rs_valid", c_rs_valid, 3'b101);
    chk("t1_x_accept", x_accept, 1);
    chk("t1_x_mem_op", x_is_mem_op, 1);
    chk("t1_x_wb", x_writeback, 1);
    @(negedge clk);
    chk("t1_outst1", outstanding, 1);
    x_valid = 0; c_is_mem_op = 0;
    c_rvalid = 1; c_rd = 5'd21; c_data = 32'hDEADBEEF;
    #1;
    chk("t1_rvalid_same_cycle", x_rvalid, 0);
    @(negedge clk);
    c_rvalid = 0;
    chk("t1_rvalid", x_rvalid, 1);
    chk("t1_rd", x_rd, 5'd21);
    chk("t1_data", x_data, 32'hDEADBEEF);
    chk("t1_error", x_error, 0);
    @(negedge clk);
    chk("t1_rvalid_done", x_rvalid, 0);
    chk("t1_outst0", outstanding, 0);

    // Handshakes without accept or without writeback push nothing
    x_valid = 1; x_instr = 32'h0000_0F8B; c_accept = 0;
    @(negedge clk);
    chk("noacc_outst", outstanding, 0);
    c_accept = 1; c_writeback = 0;
    @(negedge clk);
    chk("nowb_outst", outstanding, 0);
    c_writeback = 1;

    // Four offloads saturate the outstanding limit
    x_instr = {20'h0, 5'd1, 7'h0B};
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      x_instr = {20'h0, 5'(i), 7'h0B};
    end
    @(negedge clk);
    #1;
    chk("t2_outst4", outstanding, 4);
    chk("t2_x_ready", x_ready, 0);
    chk("t2_c_valid", c_valid, 0);
    x_valid = 0;
    c_rvalid = 1; c_rd = 5'd1; c_data = 32'h11;
    @(negedge clk);
    c_rvalid = 0;
    chk("t2_rd1", x_rd, 5'd1);
    chk("t2_still_stalled", x_ready, 0);
    @(negedge clk);
    chk("t2_outst3", outstanding, 3);
    chk("t2_ready_back", x_ready, 1);

    // Backpressure: three results against a 2-entry FIFO
    x_rready = 0;
    c_rvalid = 1; c_rd = 5'd2; c_data = 32'hA2;
    #1 chk("t3_rready0", c_rready, 1);
    @(negedge clk);
    c_rd = 5'd3; c_data = 32'hA3;
    #1 chk("t3_rready1", c_rready, 1);
    @(negedge clk);
    c_rd = 5'd4; c_data = 32'hA4;
    #1 chk("t3_rready_full", c_rready, 0);
    @(negedge clk);
    chk("t3_hold_rready", c_rready, 0);
    chk("t3_head_rd2", x_rd, 5'd2);
    chk("t3_head_data2", x_data, 32'hA2);
    chk("t3_outst", outstanding, 3);
    x_rready = 1;
    @(negedge clk);
    chk("t3_rd3", x_rd, 5'd3);
    chk("t3_data3", x_data, 32'hA3);
    chk("t3_rready_open", c_rready, 1);
    chk("t3_outst2", outstanding, 2);
    @(negedge clk);
    c_rvalid = 0;
    chk("t3_rd4", x_rd, 5'd4);
    chk("t3_data4", x_data, 32'hA4);
    chk("t3_outst1", outstanding, 1);
    @(negedge clk);
    chk("t3_empty", x_rvalid, 0);
    chk("t3_outst0", outstanding, 0);
    chk("t3_no_mism", err_mism, 0);

    // Result with no pending tag
    c_rvalid = 1; c_rd = 5'd7; c_data = 32'h77;
    #1 chk("t4_rready", c_rready, 1);
    @(negedge clk);
    c_rvalid = 0;
    chk("t4_err_unexp", err_unexp, 1);
    chk("t4_rvalid", x_rvalid, 0);
    chk("t4_outst", outstanding, 0);
    chk("t4_err_mism", err_mism, 0);

    // rd mismatch: expect 5, coprocessor returns 6
    x_valid = 1; x_instr = 32'h0000_028B;
    @(negedge clk);
    x_valid = 0;
    c_rvalid = 1; c_rd = 5'd6; c_data = 32'h55;
    @(negedge clk);
    c_rvalid = 0;
    chk("t5_err_mism", err_mism, 1);
    chk("t5_rvalid", x_rvalid, 1);
    chk("t5_rd", x_rd, 5'd6);
    chk("t5_error", x_error, 1);
    chk("t5_data", x_data, 32'h55);
    @(negedge clk);
    chk("t5_outst0", outstanding, 0);
    chk("t5_err_unexp_sticky", err_unexp, 1);

    // Reset with two buffered results
    x_rready = 0;
    x_valid = 1; x_instr = {20'h0, 5'd8, 7'h0B};
    @(negedge clk);
    x_instr = {20'h0, 5'd9, 7'h0B};
    @(negedge clk);
    x_valid = 0;
    c_rvalid = 1; c_rd = 5'd8; c_data = 32'h88;
    @(negedge clk);
    c_rd = 5'd9; c_data = 32'h99;
    @(negedge clk);
    c_rvalid = 0;
    chk("t6_pre_rvalid", x_rvalid, 1);
    chk("t6_pre_outst", outstanding, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", x_rvalid, 0);
    chk("t6_rst_outst", outstanding, 0);
    chk("t6_rst_err_unexp", err_unexp, 0);
    chk("t6_rst_err_mism", err_mism, 0);
    @(negedge clk);
    rst_n = 1'b1; x_rready = 1;
    @(negedge clk);
    chk("t6_post_rvalid", x_rvalid, 0);
    chk("t6_post_outst", outstanding, 0);
    chk("t6_post_rready", c_rready, 1);
    @(negedge clk);
    chk("t6_post_rvalid2", x_rvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_x_result_queue.md
Name: cv32e40p_x_result_queue

Overview:
- Sits between the core's X-interface and the attached coprocessor.
- Passes the request channel through, gated by an outstanding-offload limit.
- Tracks every accepted offload that will write back, buffers coprocessor results in a FIFO, and returns them to the core in order.
- Detects result protocol violations and flags them with sticky status bits.

Parameters:
- RESULT_DEPTH, 2, number of entries in the result FIFO (≥1).
- MAX_OUTSTANDING, 4, maximum accepted-with-writeback offloads not yet delivered to the core (≥1); also the depth of the tag FIFO.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived, not overridden).

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- x_valid_i  in  1  core request valid
- x_ready_o  out  1  request ready to core
- x_instr_data_i  in  32  offloaded instruction
- x_rs_i  in  3x32  source operands
- x_rs_valid_i  in  3  operand valid flags
- x_accept_o  out  1  coprocessor accept, returned to core
- x_is_mem_op_o  out  1  memory-op flag, returned to core
- x_writeback_o  out  1  writeback flag, returned to core
- x_rvalid_o  out  1  result valid to core
- x_rready_i  in  1  core ready for result
- x_rd_o  out  5  result destination register
- x_data_o  out  32  result data
- x_dualwb_o  out  1  dual writeback flag
- x_type_o  out  1  result type
- x_error_o  out  1  result error
- c_valid_o  out  1  request valid to coprocessor
- c_ready_i  in  1  coprocessor ready
- c_instr_data_o  out  32  instruction to coprocessor
- c_rs_o  out  3x32  operands to coprocessor
- c_rs_valid_o  out  3  operand valid flags
- c_accept_i  in  1  coprocessor accept
- c_is_mem_op_i  in  1  memory-op flag
- c_writeback_i  in  1  writeback flag
- c_rvalid_i  in  1  coprocessor result valid
- c_rready_o  out  1  ready for coprocessor result
- c_rd_i  in  5  result rd
- c_data_i  in  32  result data
- c_dualwb_i  in  1  dual writeback flag
- c_type_i  in  1  result type
- c_error_i  in  1  result error
- outstanding_o  out  CNT_W  current outstanding count
- err_unexpected_o  out  1  sticky: result received with no pending tag
- err_rd_mismatch_o  out  1  sticky: result rd differed from expected rd

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - counter, both FIFO pointers and both error bits clear to 0.
  - x_rvalid_o=0, outstanding_o=0, err_*_o=0.
  - Combinational outputs follow their inputs as defined below.
- Request path (no latency):
  - stall = (outstanding == MAX_OUTSTANDING) or (tag FIFO full).
  - c_valid_o = x_valid_i & ~stall; x_ready_o = c_ready_i & ~stall.
  - c_instr_data_o, c_rs_o, c_rs_valid_o pass x_* straight through.
  - x_accept_o, x_is_mem_op_o, x_writeback_o pass c_* straight through.
- Tag push:
  - condition: req_hs = x_valid_i & x_ready_o, with c_accept_i & c_writeback_i.
  - action: push x_instr_data_i[11:7] into the tag FIFO and increment outstanding.
  - A handshake that is not accepted, or accepted without writeback, pushes nothing.
- Result intake:
  - c_rready_o = ~result_full; res_hs = c_rvalid_i & c_rready_o.
  - Tag FIFO empty at res_hs: set err_unexpected_o; the result is consumed and dropped (no push).
  - Otherwise: push {c_rd_i, c_data_i, c_dualwb_i, c_type_i, c_error_i} and pop the tag.
  - If c_rd_i ≠ tag head: set err_rd_mismatch_o and store the entry with its error bit forced to 1.
- Tag push and tag pop in the same cycle are both performed. At full, no push can occur because of stall.
- Result output:
  - x_rvalid_o = ~result_empty; x_rd_o..x_error_o come from the FIFO head.
  - Minimum latency c_rvalid_i to x_rvalid_o is 1 cycle; in-order only.
  - Pop on x_rvalid_o & x_rready_i; each pop decrements outstanding.
- Counter: increment and decrement in the same cycle leave it unchanged. It never wraps (stall guarantees this).
- Full-throughput FIFO: pop and push in the same cycle while full is not allowed (c_rready_o=0 when full). Pop and push on a non-empty, non-full FIFO are both performed.
- Error bits are sticky until reset.

Test Plan:
- Accept with writeback, instr 0x0000_0A8B (rd=21); coprocessor returns rd=21, data=0xDEADBEEF; core ready → x_rvalid_o one cycle after c_rvalid_i with x_rd_o=21, x_data_o=0xDEADBEEF, x_error_o=0; outstanding goes 1→0.
- Four accepted writeback offloads with no results → outstanding_o=4, x_ready_o=0 and c_valid_o=0 even with c_ready_i=1; one result delivered → ready reasserts the next cycle.
- x_rready_i=0 and three results arrive with RESULT_DEPTH=2 → c_rready_o drops after 2 pushes; releasing x_rready_i drains the results in order with the data values intact.
- c_rvalid_i with no pending tag → err_unexpected_o=1 from the next cycle; x_rvalid_o stays 0; outstanding stays 0.
- Expected rd=5, coprocessor returns rd=6 → err_rd_mismatch_o=1 and the delivered entry has x_error_o=1, x_rd_o=6.
- Reset asserted with 2 results buffered → x_rvalid_o=0, outstanding_o=0, error bits 0 immediately; no stale result appears after reset release.
